// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//
// Execute-issue stage in front of the combinational RV32I ALU. One decoded
// instruction per cycle is accepted over a valid/ready handshake. At capture
// time the stage picks register/PC/immediate operands, applies write-back
// forwarding, and normalises the operands so the ALU computes RV32I semantics.
// The processed entries are held in a two-entry skid buffer, so the registered
// o_in_ready still sustains one instruction per cycle.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. Valid never depends combinationally on
// ready. Once o_out_valid is raised, it and every payload output hold stable
// until o_out_ready accepts the transfer.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   : write-back bypass (i_fwd_*) replaces rs1/rs2 read data.
//   undefined : i_fwd_* are ignored.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_in_valid / o_in_ready    upstream handshake (o_in_ready is registered)
//   i_rs1_data, i_rs2_data     register-file read data
//   i_pc, i_imm                instruction PC, sign-extended immediate
//   i_rs1_addr, i_rs2_addr     source register numbers
//   i_rd_addr_in               destination register number
//   i_op1_sel, i_op2_sel       0 = rs1/rs2, 1 = pc/imm
//   i_func3_in, i_subsra_in    ALU function and SUB/SRA select
//   i_reg_write_in             destination write enable
//   i_fwd_valid/_rd/_data      write-back bypass
//   i_flush                    synchronous discard of all held entries
//   o_out_valid / i_out_ready  downstream handshake
//   o_operand1, o_operand2     ALU operands
//   o_func3, o_subsra          ALU controls
//   o_rd_addr, o_reg_write     passed through for write-back
//   o_dbg_state                skid-buffer FSM state (0 EMPTY, 1 ONE, 2 FULL)

module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rd_addr_in,
  input  logic            i_op1_sel,
  input  logic            i_op2_sel,
  input  logic [2:0]      i_func3_in,
  input  logic            i_subsra_in,
  input  logic            i_reg_write_in,
  input  logic            i_fwd_valid,
  input  logic [4:0]      i_fwd_rd,
  input  logic [XLEN-1:0] i_fwd_data,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_operand1,
  output logic [XLEN-1:0] o_operand2,
  output logic [2:0]      o_func3,
  output logic            o_subsra,
  output logic [4:0]      o_rd_addr,
  output logic            o_reg_write,
  output logic [1:0]      o_dbg_state
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      func3;
    logic            subsra;
    logic [4:0]      rd;
    logic            reg_write;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_in_ready;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_new;

  logic            w_accept;
  logic            w_fire;
  logic            w_out_valid;
  logic            w_load_main_new;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic            w_fwd1;
  logic            w_fwd2;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;

  // ---------------------------------------------------------------------------
  // Forwarding: x0 is hardwired zero, so a bypass to rd 0 is never honoured.
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_FWD_EN
  assign w_fwd1 = i_fwd_valid && (i_fwd_rd != 5'd0) && (i_fwd_rd == i_rs1_addr);
  assign w_fwd2 = i_fwd_valid && (i_fwd_rd != 5'd0) && (i_fwd_rd == i_rs2_addr);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_fwd_valid, i_fwd_rd, i_fwd_data, i_rs1_addr, i_rs2_addr};
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign w_rs1 = w_fwd1 ? i_fwd_data : i_rs1_data;
  assign w_rs2 = w_fwd2 ? i_fwd_data : i_rs2_data;

  // ---------------------------------------------------------------------------
  // Operand selection and normalisation of the incoming instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_new           = '0;
    w_new.op1       = i_op1_sel ? i_pc  : w_rs1;
    w_new.op2       = i_op2_sel ? i_imm : w_rs2;
    w_new.func3     = i_func3_in;
    w_new.rd        = i_rd_addr_in;
    w_new.reg_write = i_reg_write_in;
    // No SUBI exists: the immediate form of func3 000 is always an add.
    w_new.subsra    = (i_op2_sel && (i_func3_in == 3'b000)) ? 1'b0 : i_subsra_in;
    case (i_func3_in)
      // Shifts: only the 5-bit shamt may reach the ALU.
      3'b001, 3'b101: w_new.op2[XLEN-1:5] = '0;
      // SLT: flipping both sign bits turns the ALU's unsigned compare signed.
      3'b010: begin
        w_new.op1[XLEN-1] = ~w_new.op1[XLEN-1];
        w_new.op2[XLEN-1] = ~w_new.op2[XLEN-1];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid buffer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != S_FULL);
    end
  end

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = i_in_valid && r_in_ready;
  assign w_fire      = w_out_valid && i_out_ready;

  // Skid buffer FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_next_state = S_ONE;
      S_ONE: begin
        if (w_accept && !w_fire)      w_next_state = S_FULL;
        else if (!w_accept && w_fire) w_next_state = S_EMPTY;
      end
      S_FULL:  if (w_fire) w_next_state = S_ONE;
      default: w_next_state = S_EMPTY;
    endcase
    // Flush wins over any same-cycle accept; that input is dropped.
    if (i_flush) w_next_state = S_EMPTY;
  end

  // Skid buffer FSM: output / load-enable logic
  always_comb begin
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!i_flush) begin
      case (r_state)
        S_EMPTY: w_load_main_new = w_accept;
        S_ONE: begin
          w_load_main_new = w_accept && w_fire;
          w_load_skid     = w_accept && !w_fire;
        end
        S_FULL:  w_load_main_skid = w_fire;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage. The main entry always drives the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (i_flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_new)       r_main <= w_new;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_new;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_operand1  = r_main.op1;
  assign o_operand2  = r_main.op2;
  assign o_func3     = r_main.func3;
  assign o_subsra    = r_main.subsra;
  assign o_rd_addr   = r_main.rd;
  assign o_reg_write = r_main.reg_write;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenario tasks plus randomized traffic,
// all checked against a queue-based reference model of the stage.

module tb_alu_issue_stage;

  localparam int XLEN = 32;
  localparam int EW   = 2 * XLEN + 3 + 1 + 5 + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] rs1_data, rs2_data, pc, imm;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr_in;
  logic            op1_sel, op2_sel;
  logic [2:0]      func3_in;
  logic            subsra_in, reg_write_in;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] operand1, operand2;
  logic [2:0]      func3;
  logic            subsra;
  logic [4:0]      rd_addr;
  logic            reg_write;
  logic [1:0]      dbg_state;

  int n_vec  = 0;
  int n_err  = 0;
  int n_fire = 0;

  // Reference model state: pending instructions in order, and expected in_ready.
  logic [EW-1:0] exp_q[$];
  logic          m_rdy = 1'b1;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_pc(pc), .i_imm(imm),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr_in(rd_addr_in),
    .i_op1_sel(op1_sel), .i_op2_sel(op2_sel),
    .i_func3_in(func3_in), .i_subsra_in(subsra_in), .i_reg_write_in(reg_write_in),
    .i_fwd_valid(fwd_valid), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_operand1(operand1), .o_operand2(operand2),
    .o_func3(func3), .o_subsra(subsra),
    .o_rd_addr(rd_addr), .o_reg_write(reg_write),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  // What the ALU should see for the instruction currently on the inputs.
  function automatic logic [EW-1:0] model_entry();
    logic [XLEN-1:0] a, b;
    logic            ss;
    a = rs1_data;
    b = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == rs1_addr) a = fwd_data;
    if (fwd_valid && fwd_rd != 0 && fwd_rd == rs2_addr) b = fwd_data;
`endif
    if (op1_sel) a = pc;
    if (op2_sel) b = imm;
    if (func3_in == 3'd1 || func3_in == 3'd5) b = b % 32;
    if (func3_in == 3'd2) begin
      a = a ^ 32'h8000_0000;
      b = b ^ 32'h8000_0000;
    end
    ss = (op2_sel && func3_in == 3'd0) ? 1'b0 : subsra_in;
    return {a, b, func3_in, ss, rd_addr_in, reg_write_in};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rdy = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      m_rdy = 1'b1;
    end else begin
      logic acc, fire;
      acc  = in_valid && m_rdy;
      fire = (exp_q.size() > 0) && out_ready;
      if (fire) begin
        void'(exp_q.pop_front());
        n_fire++;
      end
      if (acc) exp_q.push_back(model_entry());
      m_rdy = (exp_q.size() < 2);
    end
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL sb_handshake: got valid=%b ready=%b want valid=%b ready=%b",
                 out_valid, in_ready, exp_q.size() > 0, m_rdy);
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        if ({operand1, operand2, func3, subsra, rd_addr, reg_write} !== exp_q[0]) begin
          n_err++;
          $display("FAIL sb_payload: got %h want %h",
                   {operand1, operand2, func3, subsra, rd_addr, reg_write}, exp_q[0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic clear_inputs();
    in_valid = 0; rs1_data = 0; rs2_data = 0; pc = 0; imm = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr_in = 0; op1_sel = 0; op2_sel = 0;
    func3_in = 0; subsra_in = 0; reg_write_in = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic rand_fields();
    rs1_data = $urandom; rs2_data = $urandom; pc = $urandom; imm = $urandom;
    rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
    rd_addr_in = 5'($urandom_range(0, 31));
    op1_sel = 1'($urandom_range(0, 1)); op2_sel = 1'($urandom_range(0, 1));
    func3_in = 3'($urandom_range(0, 7)); subsra_in = 1'($urandom_range(0, 1));
    reg_write_in = 1'($urandom_range(0, 1));
    fwd_valid = 1'($urandom_range(0, 1)); fwd_rd = 5'($urandom_range(0, 3));
    fwd_data = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 0; flush = 0; out_ready = 1;
    end
  endtask

  // Present one instruction (already in the input regs) for exactly one edge.
  task automatic send_one();
    @(posedge clk); #1;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    n_vec++;
    if ({operand1, operand2, func3, subsra, rd_addr, reg_write} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got %h want 0", {operand1, operand2, func3, subsra, rd_addr, reg_write});
    end
  endtask

  task automatic test_add();
    clear_inputs();
    rs1_data = 5; rs2_data = 7; rd_addr_in = 9; reg_write_in = 1;
    send_one();
    n_vec++;
    if (out_valid !== 1'b1 || operand1 !== 32'd5 || operand2 !== 32'd7 || func3 !== 3'd0) begin
      n_err++;
      $display("FAIL add: got v=%b %h %h f=%0d want 1 5 7 0", out_valid, operand1, operand2, func3);
    end
    n_vec++;
    if (rd_addr !== 5'd9 || reg_write !== 1'b1 || subsra !== 1'b0) begin
      n_err++;
      $display("FAIL add_ctl: got rd=%0d rw=%b ss=%b want 9 1 0", rd_addr, reg_write, subsra);
    end
    idle(2);
  endtask

  task automatic test_addi();
    clear_inputs();
    imm = 32'hFFFF_FFFF; op2_sel = 1; subsra_in = 1; rs1_data = 32'h10;
    send_one();
    n_vec++;
    if (operand2 !== 32'hFFFF_FFFF || subsra !== 1'b0) begin
      n_err++;
      $display("FAIL addi: got op2=%h ss=%b want ffffffff 0", operand2, subsra);
    end
    idle(2);
    // SRAI keeps its subsra bit while the immediate is trimmed to shamt
    clear_inputs();
    imm = 32'h0000_0413; op2_sel = 1; func3_in = 3'b101; subsra_in = 1;
    send_one();
    n_vec++;
    if (operand2 !== 32'h13 || subsra !== 1'b1) begin
      n_err++;
      $display("FAIL srai: got op2=%h ss=%b want 13 1", operand2, subsra);
    end
    idle(2);
  endtask

  task automatic test_shift_slt();
    clear_inputs();
    imm = 32'h0000_0425; op2_sel = 1; func3_in = 3'b001;
    send_one();
    n_vec++;
    if (operand2 !== 32'h0000_0005) begin
      n_err++;
      $display("FAIL slli: got %h want 00000005", operand2);
    end
    idle(2);
    clear_inputs();
    rs1_data = 32'hFFFF_FFFF; rs2_data = 1; func3_in = 3'b010;
    send_one();
    n_vec++;
    if (operand1 !== 32'h7FFF_FFFF || operand2 !== 32'h8000_0001) begin
      n_err++;
      $display("FAIL slt: got %h %h want 7fffffff 80000001", operand1, operand2);
    end
    idle(2);
    clear_inputs();
    rs1_data = 32'hFFFF_FFFF; rs2_data = 1; func3_in = 3'b011;
    send_one();
    n_vec++;
    if (operand1 !== 32'hFFFF_FFFF || operand2 !== 32'h1) begin
      n_err++;
      $display("FAIL sltu: got %h %h want ffffffff 00000001", operand1, operand2);
    end
    idle(2);
  endtask

  task automatic test_forward();
    logic [XLEN-1:0] e1;
    clear_inputs();
    rs1_data = 32'h1234; rs2_data = 32'h5678; rs1_addr = 3; rs2_addr = 4;
    fwd_valid = 1; fwd_rd = 3; fwd_data = 32'hDEAD;
`ifdef ALU_ISSUE_FWD_EN
    e1 = 32'hDEAD;
`else
    e1 = 32'h1234;
`endif
    out_ready = 0;
    send_one();
    fwd_data = 32'hBEEF; // held entries must not pick up a later bypass
    n_vec++;
    if (operand1 !== e1 || operand2 !== 32'h5678) begin
      n_err++;
      $display("FAIL fwd_rs1: got %h %h want %h 00005678", operand1, operand2, e1);
    end
    @(posedge clk); #1;
    n_vec++;
    if (operand1 !== e1) begin
      n_err++;
      $display("FAIL fwd_hold: got %h want %h", operand1, e1);
    end
    out_ready = 1;
    idle(2);
    clear_inputs();
    rs1_data = 32'h1234; rs1_addr = 0; fwd_valid = 1; fwd_rd = 0; fwd_data = 32'hDEAD;
    send_one();
    n_vec++;
    if (operand1 !== 32'h1234) begin
      n_err++;
      $display("FAIL fwd_x0: got %h want 00001234", operand1);
    end
    idle(2);
  endtask

  // Fill both entries with out_ready low: A then B.
  task automatic fill_two();
    clear_inputs();
    out_ready = 0;
    rs1_data = 32'h111; rd_addr_in = 1;
    @(posedge clk); #1;
    in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    rs1_data = 32'h222; rd_addr_in = 2;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    fill_two();
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || operand1 !== 32'h111) begin
      n_err++;
      $display("FAIL bp_full: got ready=%b valid=%b op1=%h want 0 1 111", in_ready, out_valid, operand1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (operand1 !== 32'h111 || rd_addr !== 5'd1 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_stable: got op1=%h rd=%0d v=%b want 111 1 1", operand1, rd_addr, out_valid);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    n_vec++;
    if (operand1 !== 32'h222 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second: got op1=%h v=%b ready=%b want 222 1 1", operand1, out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got valid=%b want 0", out_valid);
    end
    idle(1);
  endtask

  task automatic test_flush();
    fill_two();
    rs1_data = 32'h333; rd_addr_in = 3;
    in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_drop: got valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    clear_inputs();
    @(posedge clk); #1;
    f0 = n_fire;
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    n_vec++;
    if (n_fire - f0 !== 8) begin
      n_err++;
      $display("FAIL b2b_count: got %0d want 8", n_fire - f0);
    end
    idle(1);
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rand_fields();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
    end
    idle(3);
  endtask

  task automatic test_async_reset();
    fill_two();
    #3;
    rst_n = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || operand1 !== '0 || rd_addr !== 5'd0) begin
      n_err++;
      $display("FAIL async_rst: got v=%b r=%b op1=%h rd=%0d want 0 1 0 0", out_valid, in_ready, operand1, rd_addr);
    end
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    idle(2);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    idle(1);
    test_add();
    test_addi();
    test_shift_slt();
    test_forward();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
